// File: rtl/sa_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// sa_feeder : holds one SA job (data + Q/K/V weights), streams it to the SA
//             core on start, then counts result beats and reports done/err.
// Rev 1.0
// ============================================================================
module sa_feeder #(
   parameter int TIMEOUT = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ld_en,
   input  logic [1:0] ld_sel,
   input  logic [5:0] ld_addr,
   input  logic [7:0] ld_data,
   input  logic       start,
   input  logic [3:0] start_T,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       in_valid,
   output logic [3:0] T,
   output logic [7:0] in_data,
   output logic [7:0] w_Q,
   output logic [7:0] w_K,
   output logic [7:0] w_V,
   input  logic       out_valid
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] C_TMAX = TW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    r_state;
   logic [7:0]    r_k;
   logic [6:0]    r_r;
   logic [TW-1:0] r_timer;
   logic [3:0]    r_t;
   logic          r_perr;

   logic [7:0] r_dat [64];
   logic [7:0] r_wq  [64];
   logic [7:0] r_wk  [64];
   logic [7:0] r_wv  [64];

   logic       w_idle;
   logic       w_t_legal;
   logic [7:0] w_kn;
   logic [3:0] w_tn;
   logic [7:0] w_lim;
   logic [5:0] w_idx;
   logic       w_ld_d0;
   logic       w_ld_q0;
   logic [6:0] w_r_inc;
   logic [6:0] w_rlim;
   logic [7:0] w_nxt_data;
   logic [7:0] w_nxt_q;
   logic [7:0] w_nxt_k;
   logic [7:0] w_nxt_v;

   assign w_idle    = (r_state == S_IDLE);
   assign busy      = !w_idle;
   assign w_t_legal = (start_T == 4'd1) || (start_T == 4'd4) || (start_T == 4'd8);

   // Index of the beat to be registered at the next edge: beat 0 on launch.
   assign w_kn    = w_idle ? 8'd0 : (r_k + 8'd1);
   assign w_tn    = w_idle ? start_T : r_t;
   assign w_lim   = {1'b0, w_tn, 3'b000};
   assign w_idx   = w_kn[5:0];
   assign w_r_inc = r_r + 7'd1;
   assign w_rlim  = {r_t, 3'b000};

   // A load landing in the launch cycle must reach beat 0 of the stream.
   assign w_ld_d0 = ld_en && (ld_sel == 2'd0) && (ld_addr == 6'd0);
   assign w_ld_q0 = ld_en && (ld_sel == 2'd1) && (ld_addr == 6'd0);

   always_comb begin
      w_nxt_data = 8'd0;
      w_nxt_q    = 8'd0;
      w_nxt_k    = 8'd0;
      w_nxt_v    = 8'd0;
      if (w_kn < w_lim)
         w_nxt_data = (w_idle && w_ld_d0) ? ld_data : r_dat[w_idx];
      case (w_kn[7:6])
         2'd0:    w_nxt_q = (w_idle && w_ld_q0) ? ld_data : r_wq[w_idx];
         2'd1:    w_nxt_k = r_wk[w_idx];
         2'd2:    w_nxt_v = r_wv[w_idx];
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) begin
            r_dat[i] <= 8'd0;
            r_wq[i]  <= 8'd0;
            r_wk[i]  <= 8'd0;
            r_wv[i]  <= 8'd0;
         end
      end else if (w_idle && ld_en) begin
         case (ld_sel)
            2'd0:    r_dat[ld_addr] <= ld_data;
            2'd1:    r_wq[ld_addr]  <= ld_data;
            2'd2:    r_wk[ld_addr]  <= ld_data;
            default: r_wv[ld_addr]  <= ld_data;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_k      <= 8'd0;
         r_r      <= 7'd0;
         r_timer  <= '0;
         r_t      <= 4'd0;
         r_perr   <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         in_valid <= 1'b0;
         T        <= 4'd0;
         in_data  <= 8'd0;
         w_Q      <= 8'd0;
         w_K      <= 8'd0;
         w_V      <= 8'd0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_t_legal) begin
                     r_t      <= start_T;
                     r_k      <= 8'd0;
                     r_state  <= S_SEND;
                     in_valid <= 1'b1;
                     T        <= start_T;
                     in_data  <= w_nxt_data;
                     w_Q      <= w_nxt_q;
                     w_K      <= w_nxt_k;
                     w_V      <= w_nxt_v;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_SEND: begin
               if (out_valid)
                  r_perr <= 1'b1;
               T <= 4'd0;
               if (r_k == 8'd191) begin
                  in_valid <= 1'b0;
                  in_data  <= 8'd0;
                  w_Q      <= 8'd0;
                  w_K      <= 8'd0;
                  w_V      <= 8'd0;
                  r_r      <= 7'd0;
                  r_timer  <= '0;
                  r_state  <= S_WAIT;
               end else begin
                  r_k     <= w_kn;
                  in_data <= w_nxt_data;
                  w_Q     <= w_nxt_q;
                  w_K     <= w_nxt_k;
                  w_V     <= w_nxt_v;
               end
            end
            S_WAIT: begin
               r_timer <= r_timer + TW'(1);
               if (out_valid)
                  r_r <= w_r_inc;
               // A final result arriving on the timeout cycle still counts as success.
               if (out_valid && (w_r_inc == w_rlim)) begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
                  err     <= r_perr;
                  r_perr  <= 1'b0;
               end else if (r_timer == C_TMAX) begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
                  err     <= 1'b1;
                  r_perr  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
